// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM encoding and sizing helpers for the serial subtractor
package serial_arith_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;

    function automatic int slices(input int w, input int b);
        return w / b;
    endfunction

    function automatic int cnt_width(input int n);
        return n <= 1 ? 1 : $clog2(n);
    endfunction

    function automatic bit split_ok(input int w, input int b);
        return b > 0 && w % b == 0;
    endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit x - y - bi with borrow-out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a-b-bin (or b-a-bin), BITS_PER_CYCLE bits per clock, LSB slice first
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             swap,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int N  = slices(WIDTH, BITS_PER_CYCLE);
    localparam int CW = cnt_width(N);

    if (!split_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_split
        $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
    end

    state_t                    state;
    logic [WIDTH-1:0]          xs, ys, rs, rs_next;
    logic                      br, last;
    logic [CW-1:0]             cnt;
    logic [BITS_PER_CYCLE-1:0] ds;
    logic [BITS_PER_CYCLE:0]   bc;

    assign bc[0] = br;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fs
        full_subtractor u_fs (.x(xs[i]), .y(ys[i]), .bi(bc[i]), .d(ds[i]), .bo(bc[i+1]));
    end

    // result enters at the top so the first (LSB) slice ends up at bit 0 after N shifts
    assign rs_next = (rs >> BITS_PER_CYCLE) | (WIDTH'(ds) << (WIDTH - BITS_PER_CYCLE));
    assign last    = cnt == CW'(N - 1);
    assign busy    = state == RUN;
    assign done    = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            rs    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else if (state != RUN) begin
            state <= start ? RUN : IDLE;
            if (start) begin
                xs  <= swap ? b : a;
                ys  <= swap ? a : b;
                br  <= bin;
                cnt <= '0;
            end
        end else begin
            xs  <= xs >> BITS_PER_CYCLE;
            ys  <= ys >> BITS_PER_CYCLE;
            rs  <= rs_next;
            br  <= bc[BITS_PER_CYCLE];
            cnt <= cnt + 1'b1;
            if (last) begin
                state <= DONE;
                diff  <= rs_next;
                bout  <= bc[BITS_PER_CYCLE];
                zero  <= rs_next == '0 && !bc[BITS_PER_CYCLE];
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table plus multi-cycle corner sequences and a 16-bit sweep
module tb_serial_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, bin, swap;
    logic [7:0] a, b;
    wire        busy, done, bout, zero;
    wire  [7:0] diff;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin), .swap(swap),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
    );

    logic        start16, bin16;
    logic [15:0] a16, b16;
    wire  [15:0] d16 [4];
    wire         bsy16 [4], dn16 [4], bo16 [4], z16 [4];

    for (genvar j = 0; j < 4; j++) begin : g_sweep
        serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(j == 0 ? 1 : j == 1 ? 2 : j == 2 ? 4 : 16)) u (
            .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16), .swap(1'b0),
            .busy(bsy16[j]), .done(dn16[j]), .diff(d16[j]), .bout(bo16[j]), .zero(z16[j])
        );
    end

    typedef struct {
        logic [7:0] a, b;
        logic       bin, swap;
        logic [7:0] d;
        logic       bo, z;
    } vec_t;

    vec_t v [9];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int bpc(input int j);
        return j == 0 ? 1 : j == 1 ? 2 : j == 2 ? 4 : 16;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xbin, input logic xswap,
                        output int lat, output int bcnt);
        a = xa; b = xb; bin = xbin; swap = xswap; start = 1'b1;
        step;
        start = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            if (busy) bcnt++;
            step;
            if (done) lat = k;
        end
    endtask

    task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic xbin);
        int          lat [4];
        logic [16:0] r;
        a16 = xa; b16 = xb; bin16 = xbin; start16 = 1'b1;
        r = {1'b0, xa} - {1'b0, xb} - 17'(xbin);
        step;
        start16 = 1'b0;
        for (int j = 0; j < 4; j++) lat[j] = -1;
        for (int k = 1; k <= 20; k++) begin
            step;
            for (int j = 0; j < 4; j++) if (dn16[j] && lat[j] < 0) lat[j] = k;
        end
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("sweep bpc%0d latency", bpc(j)), lat[j], 16 / bpc(j));
            chk($sformatf("sweep bpc%0d diff %h-%h-%0d", bpc(j), xa, xb, xbin), d16[j], r[15:0]);
            chk($sformatf("sweep bpc%0d bout", bpc(j)), bo16[j], r[16]);
            chk($sformatf("sweep bpc%0d zero", bpc(j)), z16[j], r == 17'd0);
        end
    endtask

    initial begin
        int lat, bcnt, pulses, held;
        v[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        v[1] = '{8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};
        v[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        v[3] = '{8'h7A, 8'h7A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        v[4] = '{8'h03, 8'h05, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};
        v[5] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
        v[6] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        v[7] = '{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
        v[8] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'hF1, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; swap = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        step; step;
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);
        chk("reset zero", zero, 0);

        for (int i = 0; i < 9; i++) begin
            run8(v[i].a, v[i].b, v[i].bin, v[i].swap, lat, bcnt);
            chk($sformatf("vec%0d latency", i), lat, 8);
            chk($sformatf("vec%0d busy cycles", i), bcnt, 8);
            chk($sformatf("vec%0d diff", i), diff, v[i].d);
            chk($sformatf("vec%0d bout", i), bout, v[i].bo);
            chk($sformatf("vec%0d zero", i), zero, v[i].z);
        end

        // reset while the third slice is pending
        a = 8'h05; b = 8'h03; bin = 1'b0; swap = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        rst = 1'b1;
        step;
        chk("midrun rst busy", busy, 0);
        chk("midrun rst done", done, 0);
        chk("midrun rst diff", diff, 0);
        chk("midrun rst bout", bout, 0);
        chk("midrun rst zero", zero, 0);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            step;
            if (done) pulses++;
        end
        chk("no done after rst", pulses, 0);

        // back-to-back: start held through the DONE cycle
        run8(8'h03, 8'h05, 1'b0, 1'b1, lat, bcnt);
        chk("b2b first latency", lat, 8);
        chk("b2b first diff", diff, 8'h02);
        a = 8'h10; b = 8'h01; swap = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        lat = -1;
        held = 1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            if (diff !== 8'h02) held = 0;
            step;
            if (done) lat = k;
        end
        chk("b2b second latency", lat, 8);
        chk("b2b first result held", held, 1);
        chk("b2b second diff", diff, 8'h0F);
        chk("b2b second bout", bout, 0);

        // start pulse and operand change during RUN must be ignored
        a = 8'h03; b = 8'h05; bin = 1'b0; swap = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            start = k == 3;
            if (k == 3) begin a = 8'h00; b = 8'h00; end
            step;
            if (done) lat = k;
        end
        start = 1'b0;
        chk("ignored start latency", lat, 8);
        chk("ignored start diff", diff, 8'hFE);
        chk("ignored start bout", bout, 1);
        pulses = 0;
        repeat (12) begin
            step;
            if (done) pulses++;
        end
        chk("ignored start extra done", pulses, 0);

        run16(16'h1234, 16'h1234, 1'b0);
        run16(16'h0000, 16'h0000, 1'b1);
        for (int t = 0; t < 4; t++) run16(16'($urandom), 16'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
